instr_encoder: RTL and testbench

Sequential RV32I instruction encoder and instruction-memory writer. It accepts field-level requests (format class, registers, funct fields, immediate) over a valid/ready handshake and checks each request for legality. Each legal request is assembled into a 32-bit instruction word and written, one word per request, into consecutive instruction-memory addresses. It sits beside the pipeline's instruction memory as the program-loading front end, producing exactly the opcode/format encodings that the pipeline's decode stage consumes.

---
 rtl/instr_encoder.sv | 162 ++++++++++++++++
 tb/tb_instr_encoder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: takes field-level requests, checks legality and writes
// each legal encoded word to consecutive instruction-memory addresses.
`timescale 1ns/1ps
module instr_encoder #(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clear,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [3:0]                 i_fmt,
    input  logic [4:0]                 i_rd,
    input  logic [4:0]                 i_rs1,
    input  logic [4:0]                 i_rs2,
    input  logic [2:0]                 i_funct3,
    input  logic [6:0]                 i_funct7,
    input  logic [31:0]                i_imm,
    output logic                       o_mem_we,
    output logic [ADDR_W-1:0]          o_mem_addr,
    output logic [31:0]                o_mem_wdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_err,
    output logic [1:0]                 o_err_code
);
    localparam int unsigned CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, ENC, WR} state_t;
    typedef enum logic [3:0] {
        F_R, F_LOAD, F_OPIMM, F_JALR, F_STORE, F_BRANCH, F_JAL, F_LUI, F_AUIPC
    } fmt_t;

    localparam logic [1:0] E_NONE  = 2'b00;
    localparam logic [1:0] E_FMT   = 2'b01;
    localparam logic [1:0] E_RANGE = 2'b10;
    localparam logic [1:0] E_ALIGN = 2'b11;

    state_t      state;
    logic [3:0]  fmt_q;
    logic [4:0]  rd_q, rs1_q, rs2_q;
    logic [2:0]  f3_q;
    logic [6:0]  f7_q;
    logic [31:0] imm_q;
    logic        we_q;
    logic [31:0] word;
    logic [1:0]  chk;
    logic        i_ok, b_ok, j_ok;

    // Immediate fits when every bit above the encodable field equals its sign bit
    assign i_ok = (&imm_q[31:11]) | ~(|imm_q[31:11]);
    assign b_ok = (&imm_q[31:12]) | ~(|imm_q[31:12]);
    assign j_ok = (&imm_q[31:20]) | ~(|imm_q[31:20]);

    always_comb begin
        word = '0;
        chk  = E_NONE;
        case (fmt_q)
            F_R:      word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, 7'b0110011};
            F_LOAD: begin
                word = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0000011};
                chk  = i_ok ? E_NONE : E_RANGE;
            end
            F_OPIMM: begin
                word = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0010011};
                chk  = i_ok ? E_NONE : E_RANGE;
            end
            F_JALR: begin
                word = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b1100111};
                chk  = i_ok ? E_NONE : E_RANGE;
            end
            F_STORE: begin
                word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], 7'b0100011};
                chk  = i_ok ? E_NONE : E_RANGE;
            end
            F_BRANCH: begin
                word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11],
                        7'b1100011};
                chk  = imm_q[0] ? E_ALIGN : (b_ok ? E_NONE : E_RANGE);
            end
            F_JAL: begin
                word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, 7'b1101111};
                chk  = imm_q[0] ? E_ALIGN : (j_ok ? E_NONE : E_RANGE);
            end
            F_LUI: begin
                word = {imm_q[31:12], rd_q, 7'b0110111};
                chk  = (|imm_q[11:0]) ? E_RANGE : E_NONE;
            end
            F_AUIPC: begin
                word = {imm_q[31:12], rd_q, 7'b0010111};
                chk  = (|imm_q[11:0]) ? E_RANGE : E_NONE;
            end
            default:  chk = E_FMT;
        endcase
    end

    assign o_full      = (o_count == CW'(DEPTH));
    assign o_req_ready = (state == IDLE) && !o_full;
    // Gated by clear so a write pending in WR never reaches memory
    assign o_mem_we    = we_q & ~i_clear;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            fmt_q       <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            f3_q        <= '0;
            f7_q        <= '0;
            imm_q       <= '0;
            we_q        <= 1'b0;
            o_mem_addr  <= ADDR_W'(BASE_ADDR);
            o_mem_wdata <= '0;
            o_count     <= '0;
            o_err       <= 1'b0;
            o_err_code  <= '0;
        end else if (i_clear) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            o_mem_addr <= ADDR_W'(BASE_ADDR);
            o_count    <= '0;
            o_err      <= 1'b0;
            o_err_code <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid && o_req_ready) begin
                        fmt_q <= i_fmt;
                        rd_q  <= i_rd;
                        rs1_q <= i_rs1;
                        rs2_q <= i_rs2;
                        f3_q  <= i_funct3;
                        f7_q  <= i_funct7;
                        imm_q <= i_imm;
                        state <= ENC;
                    end
                end
                ENC: begin
                    if (chk == E_NONE) begin
                        o_mem_wdata <= word;
                        we_q        <= 1'b1;
                        state       <= WR;
                    end else begin
                        o_err <= 1'b1;
                        if (!o_err) o_err_code <= chk;
                        state <= IDLE;
                    end
                end
                WR: begin
                    we_q       <= 1'b0;
                    o_count    <= o_count + CW'(1);
                    o_mem_addr <= o_mem_addr + ADDR_W'(4);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder against a field-arithmetic reference model.
`timescale 1ns/1ps
module tb_instr_encoder;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [3:0]  fmt = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  f3 = '0;
    logic [6:0]  f7 = '0;
    logic [31:0] imm = '0;
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  count;
    logic        full, err;
    logic [1:0]  code;

    int          checks = 0;
    int          errors = 0;
    int          m_count = 0;
    logic        m_err = 1'b0;
    logic [1:0]  m_code = '0;
    logic [31:0] last_wdata = '0;
    logic [31:0] bnd [14] = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094,
                              32'd4096, 32'hFFFFF000, 32'hFFFFEFFE, 32'h000FFFFE,
                              32'h00100000, 32'hFFF00000, 32'hFFEFFFFE, 32'd1, 32'h7FFFF000};

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .ADDR_W(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_req_valid(valid),
        .o_req_ready(ready), .i_fmt(fmt), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
        .i_funct3(f3), .i_funct7(f7), .i_imm(imm), .o_mem_we(we), .o_mem_addr(addr),
        .o_mem_wdata(wdata), .o_count(count), .o_full(full), .o_err(err),
        .o_err_code(code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: place each field at its architectural bit position; ranges as signed bounds
    function automatic void ref_encode(input logic [3:0] f, input logic [4:0] d, s1, s2,
                                       input logic [2:0] t3, input logic [6:0] t7,
                                       input logic [31:0] im,
                                       output logic [31:0] w, output logic [1:0] c);
        int signed   si;
        logic [31:0] rdf, f3f, r1f, r2f;
        si  = signed'(im);
        rdf = 32'(d) << 7;
        f3f = 32'(t3) << 12;
        r1f = 32'(s1) << 15;
        r2f = 32'(s2) << 20;
        w   = '0;
        c   = 2'd0;
        case (f)
            4'd0: w = 32'h33 | rdf | f3f | r1f | r2f | (32'(t7) << 25);
            4'd1, 4'd2, 4'd3: begin
                w = (f == 4'd1 ? 32'h03 : f == 4'd2 ? 32'h13 : 32'h67)
                    | rdf | f3f | r1f | ((im & 32'hFFF) << 20);
                if (si < -2048 || si > 2047) c = 2'd2;
            end
            4'd4: begin
                w = 32'h23 | f3f | r1f | r2f | ((im & 32'h1F) << 7)
                    | (((im >> 5) & 32'h7F) << 25);
                if (si < -2048 || si > 2047) c = 2'd2;
            end
            4'd5: begin
                w = 32'h63 | f3f | r1f | r2f | (((im >> 11) & 32'h1) << 7)
                    | (((im >> 1) & 32'hF) << 8) | (((im >> 5) & 32'h3F) << 25)
                    | (((im >> 12) & 32'h1) << 31);
                if (im[0]) c = 2'd3;
                else if (si < -4096 || si > 4095) c = 2'd2;
            end
            4'd6: begin
                w = 32'h6F | rdf | (((im >> 12) & 32'hFF) << 12) | (((im >> 11) & 32'h1) << 20)
                    | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 32'h1) << 31);
                if (im[0]) c = 2'd3;
                else if (si < -1048576 || si > 1048575) c = 2'd2;
            end
            4'd7, 4'd8: begin
                w = (f == 4'd7 ? 32'h37 : 32'h17) | rdf | (im & 32'hFFFFF000);
                if ((im & 32'hFFF) != 0) c = 2'd2;
            end
            default: c = 2'd1;
        endcase
    endfunction

    task automatic send(input logic [3:0] f, input logic [4:0] d, s1, s2,
                        input logic [2:0] t3, input logic [6:0] t7, input logic [31:0] im);
        logic [31:0] w;
        logic [1:0]  c;
        ref_encode(f, d, s1, s2, t3, t7, im, w, c);
        @(negedge clk);
        fmt = f; rd = d; rs1 = s1; rs2 = s2; f3 = t3; f7 = t7; imm = im; valid = 1'b1;
        check("idle_ready", ready, 1);
        @(negedge clk);
        valid = 1'b0;
        imm = $urandom; rd = 5'($urandom); rs1 = 5'($urandom); f7 = 7'($urandom);
        check("enc_ready", ready, 0);
        check("enc_we", we, 0);
        @(negedge clk);
        if (c == 2'd0) begin
            check("wr_we", we, 1);
            check("wr_addr", addr, BASE + 4 * m_count);
            check("wr_data", wdata, w);
            check("wr_ready", ready, 0);
            last_wdata = wdata;
            @(negedge clk);
            m_count++;
            check("post_we", we, 0);
        end else begin
            check("bad_we", we, 0);
            if (!m_err) m_code = c;
            m_err = 1'b1;
        end
        check("count", count, m_count);
        check("addr", addr, BASE + 4 * m_count);
        check("err", err, m_err);
        check("code", code, m_code);
        check("full", full, m_count == DEPTH);
        check("ready", ready, m_count != DEPTH);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_count = 0; m_err = 1'b0; m_code = '0;
        check("clr_count", count, 0);
        check("clr_addr", addr, BASE);
        check("clr_err", {err, code}, 0);
        check("clr_ready", ready, 1);
    endtask

    task automatic try_full();
        @(negedge clk);
        fmt = 4'd2; imm = 32'd1; valid = 1'b1;
        check("full_ready", ready, 0);
        check("full_flag", full, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_we", we, 0);
        end
        valid = 1'b0;
        check("full_count", count, DEPTH);
    endtask

    function automatic logic [31:0] pick_imm();
        case ($urandom_range(0, 5))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       return bnd[$urandom_range(0, 13)];
            3:       return $urandom & 32'hFFFFF000;
            4:       return (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
            default: return 32'($urandom_range(0, 4095)) - 32'd2048;
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_we", we, 0);
        check("rst_addr", addr, BASE);
        check("rst_wdata", wdata, 0);
        check("rst_misc", {count, full, err, code}, 0);
        rst = 1'b0;

        send(4'd2, 5'd1, 5'd0, 5'd9, 3'd0, 7'h55, 32'd5);
        check("g_opimm", last_wdata, 32'h00500093);
        send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF);
        check("g_add", last_wdata, 32'h002081B3);
        send(4'd4, 5'd31, 5'd1, 5'd2, 3'd2, 7'h7F, 32'd8);
        check("g_store", last_wdata, 32'h0020A423);
        send(4'd5, 5'd17, 5'd1, 5'd2, 3'd0, 7'h7F, 32'hFFFFFFF8);
        check("g_branch", last_wdata, 32'hFE208CE3);
        send(4'd6, 5'd1, 5'd7, 5'd9, 3'd5, 7'h7F, 32'd16);
        check("g_jal", last_wdata, 32'h010000EF);
        send(4'd7, 5'd5, 5'd7, 5'd9, 3'd5, 7'h7F, 32'h12345000);
        check("g_lui", last_wdata, 32'h123452B7);
        send(4'd8, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000);
        send(4'd1, 5'd4, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFFF800);
        try_full();
        do_clear();

        send(4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        check("g_code_fmt", code, 2'b01);
        send(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        check("g_code_sticky", code, 2'b01);
        do_clear();
        send(4'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        check("g_code_align", code, 2'b11);
        do_clear();
        send(4'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000);
        check("g_code_range", code, 2'b10);
        do_clear();

        // Clear during WR suppresses the strobe in that same cycle
        send(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        @(negedge clk);
        fmt = 4'd2; imm = 32'd7; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        #1 check("abort_we", we, 0);
        @(negedge clk);
        clear = 1'b0;
        m_count = 0; m_err = 1'b0; m_code = '0;
        check("abort_count", count, 0);
        check("abort_ready", ready, 1);
        @(negedge clk);
        check("abort_we_after", we, 0);

        // Clear together with valid drops the request
        @(negedge clk);
        fmt = 4'd2; imm = 32'd3; valid = 1'b1; clear = 1'b1;
        @(negedge clk);
        valid = 1'b0; clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("drop_we", we, 0);
        end
        check("drop_count", count, 0);

        // Asynchronous reset while in ENC
        send(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        send(4'd15, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        @(negedge clk);
        fmt = 4'd2; imm = 32'd9; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_ready", ready, 1);
        check("arst_we", we, 0);
        check("arst_addr", addr, BASE);
        check("arst_regs", {count, err, code}, 0);
        check("arst_wdata", wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        m_count = 0; m_err = 1'b0; m_code = '0;
        @(negedge clk);
        check("arst_no_wr", we, 0);

        for (int n = 0; n < 120; n++) begin
            logic [3:0] rf;
            if (m_count == DEPTH) begin
                try_full();
                do_clear();
            end else if ($urandom_range(0, 15) == 0) begin
                do_clear();
            end
            rf = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            send(rf, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                 pick_imm());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
